// File: rtl/map_recovery_ctrl.sv
// map_recovery_ctrl: mispredict recovery sequencer (map restore, squash, FU drain, fetch redirect)
module map_recovery_ctrl #(
    parameter int MIN_DRAIN = 2,
    parameter int CNT_W     = 16,
    parameter int PC_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mispredict_valid,
    input  logic [PC_W-1:0]  mispredict_pc,
    input  logic             fu_idle,
    input  logic             redirect_ready,
    output logic             map_restore_en,
    output logic             squash,
    output logic             stall_dispatch,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             busy,
    output logic [CNT_W-1:0] recovery_count
);
    localparam int DW = $clog2(MIN_DRAIN + 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DRAIN    = 2'd1;
    localparam logic [1:0] REDIRECT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             start, in_drain, drain_done, handshake;

    // Next-state logic; a mispredict is only honoured in IDLE since later ones are already squashed
    always_comb begin
        start         = (state_q == IDLE) && mispredict_valid;
        in_drain      = state_q == DRAIN;
        drain_done    = in_drain && (int'(drain_cnt_q) + 1 >= MIN_DRAIN) && fu_idle;
        handshake     = (state_q == REDIRECT) && redirect_ready;
        state_d       = start ? DRAIN : drain_done ? REDIRECT : handshake ? IDLE : state_q;
        drain_cnt_d   = start ? '0
                      : (in_drain && int'(drain_cnt_q) < MIN_DRAIN) ? drain_cnt_q + DW'(1)
                      : drain_cnt_q;
        redirect_pc_d = start ? mispredict_pc : redirect_pc_q;
        count_d       = (start && count_q != '1) ? count_q + CNT_W'(1) : count_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            drain_cnt_q   <= '0;
            redirect_pc_q <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            redirect_pc_q <= redirect_pc_d;
            count_q       <= count_d;
        end
    end

    // Restore/squash are same-cycle so the arch snapshot includes this cycle's retire writes;
    // every output is forced low while reset is held
    always_comb begin
        map_restore_en = !reset && start;
        squash         = !reset && start;
        stall_dispatch = !reset && (start || state_q != IDLE);
        redirect_valid = !reset && state_q == REDIRECT;
        busy           = !reset && state_q != IDLE;
        redirect_pc    = reset ? '0 : redirect_pc_q;
        recovery_count = reset ? '0 : count_q;
    end
endmodule

// File: doc/map_recovery_ctrl.md
Name: map_recovery_ctrl

Overview:
Sequences branch-mispredict recovery around the speculative map table. On a mispredict reported at retire, it:
- restores the speculative map from the architected map in the same cycle;
- squashes in-flight work;
- stalls dispatch until functional units drain, so stale CDB broadcasts cannot set ready bits on reallocated tags;
- hands a redirect PC to fetch with a valid/ready handshake.

Parameters:
MIN_DRAIN, 2, minimum cycles spent in DRAIN (>=1)
CNT_W, 16, width of saturating recovery event counter
PC_W, 32, width of redirect PC

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
mispredict_valid  input  1  retire reports a mispredicted branch this cycle (single-cycle pulse)
mispredict_pc  input  PC_W  correct target PC of that branch
fu_idle  input  1  no issued op remains in any FU/CDB pipeline
redirect_ready  input  1  fetch accepts redirect
map_restore_en  output  1  drives map table table_restore_en (arch -> speculative copy)
squash  output  1  flush ROB/RS/FUs/fetch queue
stall_dispatch  output  1  block dispatch and map-table writes
redirect_valid  output  1  redirect request to fetch
redirect_pc  output  PC_W  latched target PC
busy  output  1  controller not in IDLE
recovery_count  output  CNT_W  number of recoveries started, saturating

Behaviour:
- States: IDLE, DRAIN, REDIRECT. Encoding is free.
- Reset:
  - state = IDLE; drain counter = 0; redirect_pc = 0; recovery_count = 0.
  - While reset is high, all outputs are 0 regardless of inputs.
- IDLE, mispredict_valid=1 (Mealy, same cycle):
  - map_restore_en=1, squash=1, stall_dispatch=1.
  - Same cycle because the arch table snapshot is its next-state, which includes this cycle's retire writes.
  - Register redirect_pc <= mispredict_pc; drain counter <= 0; recovery_count += 1 (saturates at all-ones); next = DRAIN.
- IDLE, mispredict_valid=0: all control outputs 0; busy=0.
- DRAIN:
  - stall_dispatch=1, busy=1; map_restore_en=0, squash=0.
  - Drain counter increments each cycle and saturates at MIN_DRAIN.
  - Exit to REDIRECT when (counter+1 >= MIN_DRAIN) && fu_idle, evaluated in the current cycle.
  - With fu_idle constantly 1, DRAIN lasts exactly MIN_DRAIN cycles.
- REDIRECT:
  - redirect_valid=1, stall_dispatch=1, busy=1; redirect_pc held stable.
  - On redirect_valid && redirect_ready: next = IDLE. stall_dispatch drops in the following cycle.
  - redirect_valid must not drop before the handshake completes.
- Mispredict while not IDLE: ignored. The retiring stream is already squashed, so no second restore, no PC update and no count increment.
- Outputs map_restore_en and squash never assert outside the IDLE→DRAIN transition cycle; they are 1-cycle pulses.
- Minimum recovery latency (fu_idle=1, redirect_ready=1), mispredict in cycle T:
  - DRAIN occupies T+1..T+MIN_DRAIN;
  - REDIRECT handshake completes at T+MIN_DRAIN+1;
  - IDLE at T+MIN_DRAIN+2.
- Reset mid-recovery: returns to IDLE next edge; any pending redirect is dropped; recovery_count is cleared.
- Width rules:
  - Drain counter is $clog2(MIN_DRAIN+1) bits.
  - recovery_count stops at 2^CNT_W-1 and never wraps.

Test Plan:
- Single mispredict, pc=0x0000_1040, fu_idle=1, redirect_ready=1, MIN_DRAIN=2 -> at T: map_restore_en=squash=stall=1; T+1,T+2: DRAIN, stall=1, redirect_valid=0; T+3: redirect_valid=1, redirect_pc=0x1040; T+4: all 0, recovery_count=1.
- fu_idle held 0 for 6 cycles after mispredict -> controller stays in DRAIN through those cycles; REDIRECT begins the cycle after fu_idle rises; map_restore_en asserted exactly once.
- redirect_ready low 4 cycles in REDIRECT -> redirect_valid and redirect_pc=0x2000 stable all 4 cycles; IDLE one cycle after ready=1.
- Second mispredict (pc=0x3000) during DRAIN and during REDIRECT -> no restore/squash pulse, redirect_pc stays at first value, recovery_count increments only once.
- Back-to-back: a new mispredict in the first IDLE cycle after a completed recovery -> immediate restore pulse, count=2.
- Reset asserted in REDIRECT -> next cycle all outputs 0, busy=0, recovery_count=0; a subsequent mispredict recovers normally.
- Saturation, with CNT_W=2: 5 recoveries -> recovery_count=3.
